dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory that answers one processor request at a time after a
// fixed number of wait states, and flags completion when DONE_ADDR is stored to.
module dmem_responder #(
    parameter int                WIDTH     = 32,
    parameter int                DEPTH     = 64,
    parameter int                WAIT      = 2,
    parameter logic [WIDTH-1:0]  DONE_ADDR = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             done,
    output logic [WIDTH-1:0] done_value,
    output logic [1:0]       state_dbg
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_* is
    // held constant from the first rsp_valid cycle until that transfer.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             c_we;
    logic [WIDTH-1:0] c_addr;
    logic [WIDTH-1:0] c_wdata;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             req_err;
    logic [WIDTH-1:0] req_rdata;
    logic             cap_err;
    logic [WIDTH-1:0] cap_rdata;

    assign state_dbg = state;

    function automatic logic is_done_store(input logic we, input logic [WIDTH-1:0] addr);
        return we && (addr == DONE_ADDR) && (DONE_ADDR[1:0] == 2'b00);
    endfunction

    // The full address takes part in the range check, so high bits never alias.
    function automatic logic calc_err(input logic we, input logic [WIDTH-1:0] addr);
        if (is_done_store(we, addr))
            return 1'b0;
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= WIDTH'(DEPTH)) || (addr == DONE_ADDR);
    endfunction

    always_comb begin
        req_err   = calc_err(req_we, req_addr);
        req_rdata = '0;
        if (!req_we && !req_err)
            req_rdata = mem[req_addr[AW+1:2]];
        cap_err   = calc_err(c_we, c_addr);
        cap_rdata = '0;
        if (!c_we && !cap_err)
            cap_rdata = mem[c_addr[AW+1:2]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            c_we       <= 1'b0;
            c_addr     <= '0;
            c_wdata    <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            done       <= 1'b0;
            done_value <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        c_we      <= req_we;
                        c_addr    <= req_addr;
                        c_wdata   <= req_wdata;
                        cnt       <= 4'(WAIT);
                        req_ready <= 1'b0;
                        if (WAIT == 0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= req_rdata;
                            rsp_err   <= req_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cap_rdata;
                        rsp_err   <= cap_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        cnt       <= '0;
                        // Stores commit only here, so an aborted transaction leaves no trace.
                        if (c_we && !cap_err) begin
                            if (is_done_store(c_we, c_addr)) begin
                                if (!done)
                                    done_value <= c_wdata;
                                done <= 1'b1;
                            end else begin
                                mem[c_addr[AW+1:2]] <= c_wdata;
                            end
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model;
// a second instance with zero wait states checks the minimum latency.
module tb_dmem_responder;

    localparam logic [31:0] DONE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata, done_value;
    logic        rsp_err, done;
    logic [1:0]  state_dbg;

    logic        req_valid_z = 1'b0, req_we_z = 1'b0, req_ready_z, rsp_valid_z, rsp_ready_z = 1'b0;
    logic [31:0] req_addr_z = '0, req_wdata_z = '0, rsp_rdata_z, done_value_z;
    logic        rsp_err_z, done_z;
    logic [1:0]  state_dbg_z;

    logic [31:0] model_mem [64];
    logic        mdone;
    logic [31:0] mdv;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT(2), .DONE_ADDR(DONE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .done(done), .done_value(done_value),
        .state_dbg(state_dbg)
    );

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT(0), .DONE_ADDR(DONE)) u_dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_z), .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
        .req_ready(req_ready_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .done(done_z), .done_value(done_value_z),
        .state_dbg(state_dbg_z)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [31:0] addr);
        if (we && addr == DONE)
            return 1'b0;
        return (addr % 4 != 0) || (addr / 4 >= 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++)
            model_mem[i] = '0;
        mdone = 1'b0;
        mdv   = '0;
    endtask

    // One full transaction on the WAIT=2 instance; optional stall with a stray request.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input bit poke);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        exp_err = model_err(we, addr);
        exp_rd  = (we || exp_err) ? 32'h0 : model_mem[addr / 4];
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'd3);
        if (!rsp_valid)
            return;
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < delay; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom | 32'h1;
            end
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (we && !exp_err) begin
            if (addr == DONE) begin
                if (!mdone)
                    mdv = wdata;
                mdone = 1'b1;
            end else begin
                model_mem[addr / 4] = wdata;
            end
        end
        @(negedge clk);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("done", 32'(done), 32'(mdone));
        check("done_value", done_value, mdv);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_done_value"}, done_value, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Store then load, full latency.
        do_txn(1'b1, 32'h8, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(1'b0, 32'h8, 32'h0, 0, 1'b0);

        // Misaligned / out-of-range / aliasing attempts leave memory untouched.
        do_txn(1'b0, 32'h6, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h200, 32'h0, 0, 1'b0);
        do_txn(1'b1, 32'h6, 32'h1234_5678, 0, 1'b0);
        do_txn(1'b1, 32'h200, 32'hCAFE_F00D, 0, 1'b0);
        do_txn(1'b1, 32'h8000_0008, 32'h5555_AAAA, 1, 1'b0);
        do_txn(1'b0, 32'h8, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h0, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h4, 32'h0, 0, 1'b0);

        // Back-pressure with a stray request that must be ignored.
        do_txn(1'b1, 32'h4, 32'h0000_0011, 4, 1'b1);
        do_txn(1'b0, 32'h4, 32'h0, 4, 1'b1);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Completion flag is sticky, value is the first one.
        do_txn(1'b1, DONE, 32'h1, 0, 1'b0);
        do_txn(1'b1, DONE, 32'h2, 0, 1'b0);
        do_txn(1'b0, DONE, 32'h0, 0, 1'b0);

        // Reset during the wait states of a store to 0x4.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("in_wait_state", 32'(state_dbg), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 32'h4, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h8, 32'h0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 63)) << 2;
                3:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                4:       a = $urandom | 32'h0000_0400;
                default: a = DONE;
            endcase
            d = $urandom;
            do_txn(1'($urandom), a, d, $urandom_range(0, 3), 1'($urandom));
        end

        // Zero wait states: response in the cycle after accept.
        d = $urandom;
        @(negedge clk);
        req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'hC; req_wdata_z = d; rsp_ready_z = 1'b1;
        @(posedge clk);
        #1;
        req_valid_z = 1'b0;
        @(negedge clk);
        check("z_store_valid", 32'(rsp_valid_z), 32'd1);
        check("z_store_err", 32'(rsp_err_z), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        req_valid_z = 1'b1; req_we_z = 1'b0; req_addr_z = 32'hC;
        @(posedge clk);
        #1;
        req_valid_z = 1'b0;
        @(negedge clk);
        check("z_load_valid", 32'(rsp_valid_z), 32'd1);
        check("z_load_rdata", rsp_rdata_z, d);
        @(posedge clk);
        #1;
        rsp_ready_z = 1'b0;
        @(negedge clk);
        check("z_idle_valid", 32'(rsp_valid_z), 32'd0);
        check("z_idle_ready", 32'(req_ready_z), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
